multisim_pull_arbiter: RTL and testbench

//   Shares one multisim_client_pull stream (one server channel) between NUM_CONSUMERS

---
 rtl/multisim_pull_arbiter.sv | 74 +++++++
 tb/tb_multisim_pull_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multisim_pull_arbiter.sv
// multisim_pull_arbiter: round-robin, burst-locked sharing of one pull-client stream among local consumers
// Ports:
//   clk, rst                      clock, async active-high reset
//   up_data_vld/up_data/up_data_rdy  pull-client side handshake
//   cons_rdy                      per-consumer ready, doubles as the request
//   cons_vld/cons_data            one-hot valid and shared beat bus from the one-entry slot
//   owner, busy                   current grantee and burst-active flag
module multisim_pull_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_CONSUMERS = 4,
  parameter int BURST_LEN     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             up_data_vld,
  input  logic [DATA_WIDTH-1:0]            up_data,
  output logic                             up_data_rdy,
  input  logic [NUM_CONSUMERS-1:0]         cons_rdy,
  output logic [NUM_CONSUMERS-1:0]         cons_vld,
  output logic [DATA_WIDTH-1:0]            cons_data,
  output logic [$clog2(NUM_CONSUMERS)-1:0] owner,
  output logic                             busy
);
  localparam int OW = $clog2(NUM_CONSUMERS);
  localparam int CW = $clog2(BURST_LEN + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state;
  logic            slot_full, found, own_rdy, up_xfer, slot_nxt, done;
  logic [OW-1:0]   rr_ptr, pick;
  logic [CW-1:0]   beat_cnt;
  assign busy        = state == BURST;
  assign own_rdy     = cons_rdy[owner];
  assign up_data_rdy = busy && beat_cnt < CW'(BURST_LEN) && (!slot_full || own_rdy);
  assign up_xfer     = up_data_vld && up_data_rdy;
  assign slot_nxt    = up_xfer || (slot_full && !own_rdy);
  // a beat accepted this cycle keeps the grant, so release only when the slot ends up empty
  assign done        = !slot_nxt && (beat_cnt == CW'(BURST_LEN) || !own_rdy);
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CONSUMERS; i++)
      if (!found && cons_rdy[(int'(rr_ptr) + i) % NUM_CONSUMERS]) begin
        found = 1'b1;
        pick  = OW'((int'(rr_ptr) + i) % NUM_CONSUMERS);
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      slot_full <= 1'b0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      owner     <= '0;
      cons_vld  <= '0;
      cons_data <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state    <= BURST;
        owner    <= pick;
        beat_cnt <= '0;
      end
    end else begin
      if (up_xfer) begin
        cons_data <= up_data;
        beat_cnt  <= beat_cnt + 1'b1;
      end
      slot_full <= slot_nxt;
      cons_vld  <= slot_nxt ? NUM_CONSUMERS'(1) << owner : '0;
      if (done) begin
        state  <= IDLE;
        rr_ptr <= owner == OW'(NUM_CONSUMERS - 1) ? '0 : owner + 1'b1;
      end
    end
endmodule

// File: tb/tb_multisim_pull_arbiter.sv
// tb_multisim_pull_arbiter: table, directed and randomized checks of multisim_pull_arbiter
module tb_multisim_pull_arbiter;
  localparam int DW = 64, N = 4, BL = 8;
  logic          clk = 0, rst = 1;
  logic          up_data_vld = 0;
  logic [DW-1:0] up_data = '0;
  logic          up_data_rdy;
  logic [N-1:0]  cons_rdy = '0, cons_vld;
  logic [DW-1:0] cons_data;
  logic [1:0]    owner;
  logic          busy;
  multisim_pull_arbiter #(.DATA_WIDTH(DW), .NUM_CONSUMERS(N), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .up_data_vld(up_data_vld), .up_data(up_data), .up_data_rdy(up_data_rdy),
    .cons_rdy(cons_rdy), .cons_vld(cons_vld), .cons_data(cons_data), .owner(owner), .busy(busy)
  );
  always #5 clk = ~clk;
  int            n_cmp = 0, n_bad = 0, cyc = 0;
  int            src_idx = 0, src_n = 0, acc_in_grant = 0;
  bit            src_on = 0;
  logic [DW-1:0] base = '0;
  int            acc_cyc[$], got_c[$], grants[$];
  logic [DW-1:0] got_d[$];
  logic          pre_busy, pre_acc;
  logic [N-1:0]  pre_rdy;
  logic [1:0]    pre_owner;
  typedef struct {
    bit vld; logic [N-1:0] rdy;
    bit e_busy; logic [1:0] e_own; bit e_urdy; logic [N-1:0] e_cvld; logic [DW-1:0] e_data;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int rr_pick(int p, logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  task automatic drive_src();
    up_data_vld = src_on && src_idx < src_n;
    up_data     = base + DW'(src_idx);
  endtask
  task automatic tick();
    #1;
    pre_busy = busy; pre_rdy = cons_rdy; pre_owner = owner; pre_acc = up_data_vld && up_data_rdy;
    if (pre_acc) begin acc_cyc.push_back(cyc); src_idx++; acc_in_grant++; end
    for (int c = 0; c < N; c++)
      if (cons_vld[c] && cons_rdy[c]) begin got_c.push_back(c); got_d.push_back(cons_data); end
    @(posedge clk); #1; cyc++;
    if (!pre_busy && busy) begin grants.push_back(int'(owner)); acc_in_grant = 0; end
    drive_src();
  endtask
  task automatic do_reset();
    rst = 1; cons_rdy = '0; src_on = 0; src_idx = 0; src_n = 0; drive_src();
    repeat (2) @(posedge clk);
    #1; rst = 0;
    acc_cyc.delete(); got_c.delete(); got_d.delete(); grants.delete();
    cyc = 0; acc_in_grant = 0;
  endtask
  task automatic run_until_got(int n, int budget);
    int b = 0;
    while (got_d.size() < n && b < budget) begin tick(); b++; end
    if (got_d.size() < n) chk("timeout_got", 64'(got_d.size()), 64'(n));
  endtask
  initial begin
    int rr_m;
    bit all_busy;
    tbl[0]  = '{0, 4'b0000, 0, 0, 0, 4'b0000, 64'h0};
    tbl[1]  = '{1, 4'b0010, 0, 0, 0, 4'b0000, 64'h0};
    tbl[2]  = '{1, 4'b0010, 1, 1, 1, 4'b0000, 64'h0};
    tbl[3]  = '{1, 4'b0010, 1, 1, 1, 4'b0010, 64'h100};
    tbl[4]  = '{0, 4'b0000, 1, 1, 0, 4'b0010, 64'h101};
    tbl[5]  = '{0, 4'b0000, 1, 1, 0, 4'b0010, 64'h101};
    tbl[6]  = '{0, 4'b0010, 1, 1, 1, 4'b0010, 64'h101};
    tbl[7]  = '{0, 4'b0000, 1, 1, 1, 4'b0000, 64'h101};
    tbl[8]  = '{0, 4'b1111, 0, 0, 0, 4'b0000, 64'h101};
    tbl[9]  = '{0, 4'b1111, 1, 2, 1, 4'b0000, 64'h101};
    tbl[10] = '{0, 4'b0000, 1, 2, 1, 4'b0000, 64'h101};
    tbl[11] = '{0, 4'b0001, 0, 0, 0, 4'b0000, 64'h101};
    tbl[12] = '{0, 4'b0001, 1, 0, 1, 4'b0000, 64'h101};
    do_reset();
    chk("reset_busy", busy, 0); chk("reset_vld", cons_vld, 0); chk("reset_urdy", up_data_rdy, 0);
    chk("reset_data", cons_data, 0);
    base = 64'h100; src_n = 1000;
    for (int k = 0; k < 13; k++) begin
      src_on = tbl[k].vld; cons_rdy = tbl[k].rdy; drive_src();
      #1;
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
      if (tbl[k].e_busy) chk($sformatf("tbl%0d_owner", k), owner, tbl[k].e_own);
      chk($sformatf("tbl%0d_urdy", k), up_data_rdy, tbl[k].e_urdy);
      chk($sformatf("tbl%0d_cvld", k), cons_vld, tbl[k].e_cvld);
      chk($sformatf("tbl%0d_data", k), cons_data, tbl[k].e_data);
      tick();
    end
    chk("tbl_ndeliv", 64'(got_d.size()), 2);
    for (int i = 0; i < got_d.size(); i++) begin
      chk("tbl_deliv_c", 64'(got_c[i]), 1); chk("tbl_deliv_d", got_d[i], 64'h100 + 64'(i));
    end
    do_reset();
    base = 0; cons_rdy = 4'b0100; src_on = 1; src_n = 20; drive_src();
    run_until_got(20, 200);
    for (int i = 0; i < got_d.size(); i++) begin
      chk("single_c", 64'(got_c[i]), 2); chk("single_d", got_d[i], 64'(i));
    end
    if (acc_cyc.size() == 20) begin
      chk("single_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 1);
      chk("single_gap8", 64'(acc_cyc[8] - acc_cyc[7]), 3);
      chk("single_gap16", 64'(acc_cyc[16] - acc_cyc[15]), 3);
      chk("single_tail", 64'(acc_cyc[19] - acc_cyc[16]), 3);
    end else chk("single_nacc", 64'(acc_cyc.size()), 20);
    chk("single_grants", 64'(grants.size()), 3);
    do_reset();
    base = 0; cons_rdy = 4'b1111; src_on = 1; src_n = 32; drive_src();
    run_until_got(32, 400);
    repeat (6) tick();
    for (int i = 0; i < got_d.size(); i++) begin
      chk("rr_c", 64'(got_c[i]), 64'(i / 8)); chk("rr_d", got_d[i], 64'(i));
    end
    chk("rr_ngrants", 64'(grants.size()), 5);
    for (int i = 0; i < grants.size() && i < 5; i++) chk("rr_grant", 64'(grants[i]), 64'(i % 4));
    do_reset();
    base = 64'h200; cons_rdy = 4'b0010; src_on = 1; src_n = 3; drive_src();
    run_until_got(3, 50);
    chk("early_busy_pre", busy, 1); chk("early_owner_pre", owner, 1);
    cons_rdy = 4'b0100;
    tick();
    chk("early_idle", busy, 0);
    tick();
    chk("early_busy", busy, 1); chk("early_owner", owner, 2);
    src_n = 13; drive_src();
    run_until_got(13, 100);
    for (int i = 3; i < got_d.size(); i++) chk("early_c2", 64'(got_c[i]), 2);
    if (acc_cyc.size() >= 12) begin
      chk("early_fullburst", 64'(acc_cyc[10] - acc_cyc[3]), 7);
      chk("early_gap", 64'(acc_cyc[11] - acc_cyc[10]), 3);
    end else chk("early_nacc", 64'(acc_cyc.size()), 12);
    do_reset();
    base = 64'h300; cons_rdy = 4'b0001; src_on = 1; src_n = 0; drive_src();
    tick(); tick();
    all_busy = 1;
    for (int i = 0; i < 50; i++) begin tick(); all_busy &= busy; end
    chk("starve_busy", all_busy, 1); chk("starve_vld", cons_vld, 0);
    src_n = 1; drive_src();
    tick();
    chk("starve_acc", 64'(acc_cyc.size()), 1);
    chk("starve_arrive_vld", cons_vld, 4'b0001); chk("starve_arrive_d", cons_data, 64'h300);
    do_reset();
    base = 64'h400; cons_rdy = 4'b0001; src_on = 1; src_n = 2; drive_src();
    tick(); tick();
    chk("rst_slot_vld", cons_vld, 4'b0001);
    cons_rdy = 4'b0000;
    tick(); #1;
    chk("bp_hold_vld", cons_vld, 4'b0001); chk("bp_hold_d", cons_data, 64'h400);
    chk("bp_urdy", up_data_rdy, 0);
    rst = 1; #1;
    chk("rst_vld", cons_vld, 0); chk("rst_busy", busy, 0); chk("rst_urdy", up_data_rdy, 0);
    @(posedge clk); #1; rst = 0;
    grants.delete(); got_d.delete(); got_c.delete();
    cons_rdy = 4'b1111;
    run_until_got(1, 20);
    if (grants.size() > 0) chk("rst_first_grant", 64'(grants[0]), 0);
    else chk("rst_ngrants", 0, 1);
    if (got_d.size() > 0) chk("rst_held_beat", got_d[0], 64'h401);
    do_reset();
    base = 0; src_n = 1 << 30; rr_m = 0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom % 3 == 0) cons_rdy = N'($urandom);
      if (!up_data_vld) begin src_on = ($urandom % 4) != 0; drive_src(); end
      tick();
      chk("rnd_onehot", 64'($countones(cons_vld) <= 1), 1);
      if (cons_vld != 0) begin
        chk("rnd_vld_owner", cons_vld, 64'(4'b0001 << owner)); chk("rnd_vld_busy", busy, 1);
      end
      if (!pre_busy) begin
        chk("rnd_grant", busy, |pre_rdy);
        if (busy) chk("rnd_pick", 64'(owner), 64'(rr_pick(rr_m, pre_rdy)));
      end else if (busy) chk("rnd_owner_stable", owner, pre_owner);
      else begin
        rr_m = (int'(pre_owner) + 1) % N;
        chk("rnd_no_abandon", 64'(src_idx - got_d.size()), 0);
      end
      if (pre_acc) chk("rnd_burst_len", 64'(acc_in_grant <= BL), 1);
    end
    for (int i = 0; i < got_d.size(); i++) chk("rnd_order", got_d[i], 64'(i));
    chk("rnd_progress", 64'(got_d.size() > 100), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
